// File: rtl/opl_bus_sequencer.sv
// Two-requester arbitrated OPL2 write sequencer driving jtopl2 wr_n/addr/din.
// Optional all-notes-off pass is built only when OPL_SILENCE_EN is defined.
module opl_bus_sequencer #(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  input  logic [15:0] s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [15:0] s1_data,
  output logic        s1_ready,
  input  logic        silence_req,
  output logic        silence_busy,
  output logic        busy,
  output logic        grant_id,
  output logic        opl_wr_n,
  output logic        opl_a0,
  output logic [7:0]  opl_din
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_STB  = 3'd1,
    ADDR_HOLD = 3'd2,
    DATA_STB  = 3'd3,
    DATA_HOLD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  cur_r_q, cur_r_d, cur_v_q, cur_v_d;
  logic        last_q, last_d, grant_id_q, grant_id_d;
  logic        wr_n_q, wr_n_d, a0_q, a0_d, busy_q, busy_d;
  logic [7:0]  din_q, din_d;
  logic        grant_s, acc0_s, acc1_s, sil_active_s;
  logic [7:0]  sil_reg_s;

`ifdef OPL_SILENCE_EN
  logic       pend_q, pend_d, run_q, run_d, sil_busy_q;
  logic [3:0] idx_q, idx_d;

  assign sil_active_s = pend_q | run_q;
  assign sil_reg_s    = (idx_q == 4'd9) ? 8'hBD : (8'hB0 | {4'h0, idx_q});
  assign silence_busy = sil_busy_q;

  // Silence request latch and write index; a pass ends after the 0xBD write returns to IDLE.
  always_comb begin
    pend_d = pend_q;
    run_d  = run_q;
    idx_d  = idx_q;
    if (silence_req && !sil_active_s) begin
      pend_d = 1'b1;
    end else if (state_q == IDLE && pend_q) begin
      pend_d = 1'b0;
      run_d  = 1'b1;
      idx_d  = 4'd0;
    end else if (run_q && state_q == DATA_HOLD && cnt_q == 16'd0) begin
      if (idx_q == 4'd9) begin
        run_d = 1'b0;
        idx_d = 4'd0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Silence state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      run_q      <= 1'b0;
      idx_q      <= 4'd0;
      sil_busy_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      run_q      <= run_d;
      idx_q      <= idx_d;
      sil_busy_q <= pend_d | run_d;
    end
  end
`else
  logic unused_silence_req_s;

  assign unused_silence_req_s = silence_req;
  assign sil_active_s         = 1'b0;
  assign sil_reg_s            = 8'h00;
  assign silence_busy         = 1'b0;
`endif

  // Round-robin: a lone requester wins, a tie goes to the one that did not win last.
  always_comb begin
    if (s0_valid && !s1_valid) begin
      grant_s = 1'b0;
    end else if (s1_valid && !s0_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = ~last_q;
    end
  end

  assign s0_ready = !rst && (state_q == IDLE) && !grant_s && !sil_active_s;
  assign s1_ready = !rst && (state_q == IDLE) &&  grant_s && !sil_active_s;
  assign acc0_s   = s0_valid & s0_ready;
  assign acc1_s   = s1_valid & s1_ready;

  // Next state; pin values are computed for the state being entered so they leave flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_r_d    = cur_r_q;
    cur_v_d    = cur_v_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    wr_n_d     = wr_n_q;
    a0_d       = a0_q;
    din_d      = din_q;
    case (state_q)
      IDLE: begin
        if (sil_active_s) begin
          cur_r_d = sil_reg_s;
          cur_v_d = 8'h00;
          state_d = ADDR_STB;
          wr_n_d  = 1'b0;
          a0_d    = 1'b0;
          din_d   = sil_reg_s;
        end else if (acc0_s || acc1_s) begin
          cur_r_d    = acc1_s ? s1_data[15:8] : s0_data[15:8];
          cur_v_d    = acc1_s ? s1_data[7:0]  : s0_data[7:0];
          grant_id_d = acc1_s;
          last_d     = acc1_s;
          state_d    = ADDR_STB;
          wr_n_d     = 1'b0;
          a0_d       = 1'b0;
          din_d      = acc1_s ? s1_data[15:8] : s0_data[15:8];
        end else begin
          state_d = IDLE;
        end
      end
      ADDR_STB: begin
        cnt_d   = 16'(ADDR_WAIT - 1);
        state_d = ADDR_HOLD;
        wr_n_d  = 1'b1;
      end
      ADDR_HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = DATA_STB;
          wr_n_d  = 1'b0;
          a0_d    = 1'b1;
          din_d   = cur_v_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA_STB: begin
        cnt_d   = 16'(DATA_WAIT - 1);
        state_d = DATA_HOLD;
        wr_n_d  = 1'b1;
      end
      DATA_HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wr_n_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Sequencer state and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      cur_r_q    <= 8'h00;
      cur_v_q    <= 8'h00;
      last_q     <= 1'b1;
      grant_id_q <= 1'b0;
      wr_n_q     <= 1'b1;
      a0_q       <= 1'b0;
      din_q      <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_r_q    <= cur_r_d;
      cur_v_q    <= cur_v_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      wr_n_q     <= wr_n_d;
      a0_q       <= a0_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign grant_id = grant_id_q;
  assign opl_wr_n = wr_n_q;
  assign opl_a0   = a0_q;
  assign opl_din  = din_q;

endmodule

// File: doc/opl_bus_sequencer.md
# opl_bus_sequencer

Arbitrated write sequencer for the jtopl2 host bus. It accepts OPL2 register/value pairs from two independent requesters, such as the PIX capture FIFO and a secondary source like a test-tone or patch loader. Each pair is converted into the two-phase OPL2 write (address strobe, then data strobe), with programmable recovery gaps between strobes. It sits between the write sources and the `jtopl2` `wr_n`/`addr`/`din` pins, in the `phi2` clock domain.

## Interface
- `ADDR_WAIT`, default 12: cycles with `wr_n` high after the address strobe. Legal range is 1..65535.
- `DATA_WAIT`, default 200: cycles with `wr_n` high after the data strobe, before the next accept. Legal range is 1..65535.
- `clk` in 1: clock (`phi2`, 8 MHz).
- `rst` in 1: reset, synchronous, active-high.
- `s0_valid` in 1: requester 0 has a pair.
- `s0_data` in 16: requester 0 pair, `{reg[15:8], val[7:0]}`.
- `s0_ready` out 1: requester 0 pair accepted this cycle.
- `s1_valid`, `s1_data`, `s1_ready`: requester 1, same meaning as requester 0.
- `silence_req` in 1: one-cycle pulse requesting all-notes-off.
- `silence_busy` out 1: silence pass pending or running.
- `busy` out 1: state is not IDLE.
- `grant_id` out 1: source of the write in flight (0 or 1). Holds its value in IDLE.
- `opl_wr_n` out 1: jtopl2 `wr_n`.
- `opl_a0` out 1: jtopl2 `addr`.
- `opl_din` out 8: jtopl2 `din`.

## Operation
- **States:**
  - IDLE → ADDR_STB → ADDR_HOLD → DATA_STB → DATA_HOLD → IDLE.
- **IDLE, accepting a pair:**
  - A pair is accepted on `sN_valid && sN_ready`.
  - `sN_ready = (state==IDLE) && grant==N && !silence_active` (combinational).
  - At most one ready is high per cycle.
  - The accepted pair is captured into `cur_r`/`cur_v` and the state goes to ADDR_STB.
- **Arbitration:**
  - Round-robin on a `last` bit.
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not `last` wins.
  - `last` updates on accept. Its reset value is 1, so s0 wins the first tie.
- **ADDR_STB (1 cycle):**
  - `opl_wr_n=0`, `opl_a0=0`, `opl_din=cur_r`.
  - The counter loads `ADDR_WAIT-1`, then the state goes to ADDR_HOLD.
- **ADDR_HOLD:**
  - `opl_wr_n=1`, `opl_a0=0`, `opl_din=cur_r`.
  - The counter decrements each cycle. At 0 the state goes to DATA_STB.
- **DATA_STB (1 cycle):**
  - `opl_wr_n=0`, `opl_a0=1`, `opl_din=cur_v`.
  - The counter loads `DATA_WAIT-1`, then the state goes to DATA_HOLD.
- **DATA_HOLD:**
  - `opl_wr_n=1`, `opl_a0=1`, `opl_din=cur_v`.
  - At counter 0 the state goes to IDLE.
- **Counter:** 16 bits, no wrap; it is only ever loaded, then decremented down to 0.
- **Valid/data stability:** `valid` must remain asserted with stable `data` until `ready`. The block never drops an accepted pair.
- **Reset (`rst` high, any state, including mid-strobe):**
  - On the next edge: `state=IDLE`, `opl_wr_n=1`, `opl_a0=0`, `opl_din=0x00`, `busy=0`, `grant_id=0`, `last=1`, `silence_busy=0`, counter 0.
  - The captured pair is discarded.
  - `sN_ready=0` while `rst` is high.

## Timing
- **Accept:** the accept edge is cycle 0; ADDR_STB is cycle 1.
- **Data strobe:** DATA_STB is cycle `ADDR_WAIT+2`.
- **Return to IDLE:** the state is IDLE again at cycle `ADDR_WAIT+DATA_WAIT+3`.
- **Throughput:** the next accept can happen in the cycle the state returns to IDLE. The write period is `ADDR_WAIT+DATA_WAIT+3` cycles.
- **Registered outputs:** all outputs are registered except `sN_ready`.
- **Strobe width:** each `wr_n` low pulse is exactly 1 cycle.
- **`busy`:** high from cycle 1 through the last DATA_HOLD cycle.

## Configuration
- Macro: `OPL_SILENCE_EN`.
- **Defined:**
  - A `silence_req` pulse sets `silence_pending`.
  - In IDLE, a pending silence has priority over s0 and s1.
  - The silence pass issues 10 internal writes through the same FSM: reg 0xB0..0xB8 with value 0x00, then reg 0xBD with value 0x00.
  - Both `sN_ready` stay 0 for the whole pass.
  - `grant_id` holds its value during the pass, and `last` is unchanged.
  - A `silence_req` that arrives while pending or running is ignored.
  - `silence_busy` goes high in the cycle after the pulse and falls when the state returns to IDLE after the 0xBD write.
- **Undefined:**
  - `silence_req` is ignored, `silence_busy` is tied to 0, and no pending/index logic is built.

## Test plan
- **Single write:** `ADDR_WAIT=2`, `DATA_WAIT=4`; s0 presents 0x2001.
  - `wr_n` is low at cycle 1 with `a0=0`, `din=0x20`.
  - `wr_n` is low at cycle 4 with `a0=1`, `din=0x01`.
  - `s0_ready` is high again at cycle 9.
- **Tie after reset:** s0=0xA041 and s1=0xB022, both valid.
  - Accept order is s0, s1, s0, s1.
  - `grant_id` follows the accept order.
  - Each accept is exactly 9 cycles apart.
- **Single requester:** only s1 is valid, with 4 back-to-back pairs.
  - All 4 are accepted with no gap beyond the 9-cycle period.
  - `s0_ready` stays 0.
- **Reset mid-write:** `rst` asserted during ADDR_HOLD.
  - Next edge: `opl_wr_n=1`, `busy=0`, no DATA_STB.
  - A fresh s0 pair afterwards completes normally.
- **Silence (`OPL_SILENCE_EN`):** `silence_req` pulses while s0 is mid-write.
  - The s0 write completes first.
  - Then 10 writes follow: regs 0xB0..0xB8, 0xBD, all with value 0x00.
  - `s0_ready` stays 0 during the pass.
  - A second pulse during the pass adds no writes.
- **Silence compiled out:** `silence_req` pulses with `OPL_SILENCE_EN` not defined.
  - No writes occur, `silence_busy` stays 0, and s0 traffic is unaffected.
